// File: rtl/reg_arbiter.sv
// Two-port register-bank arbiter: a stall-free strobe port (0) with a one-entry buffer
// and a request/grant port (1), round-robin shared onto a single register bus.
module reg_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_overrun,
    input  logic              p0_ovr_clr,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q;       // 1 = port 1 owns the current access
    logic              last_grant_q;  // 1 = port 1 was served last
    logic              we_q;
    logic              sel, sel_p1;

    logic              buf_valid_q, buf_we_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_wdata_q;

    logic              p0_strobe, p0_consume, p0_accept, p0_drop;

    assign p0_strobe  = p0_read | p0_write;
    assign p0_consume = (state_q == ISSUE) && !owner_q;
    assign p0_accept  = p0_strobe && (!buf_valid_q || p0_consume);
    // A simultaneous read+write is still accepted (as a write) but is flagged as a loss.
    assign p0_drop    = (p0_strobe && !p0_accept) || (p0_read && p0_write);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel     = 1'b0;
        sel_p1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_valid_q || p1_req) begin
                    sel     = 1'b1;
                    sel_p1  = p1_req && (!buf_valid_q || !last_grant_q);
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = we_q ? IDLE : RDWAIT;
            RDWAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
        end else if (sel) begin
            owner_q      <= sel_p1;
            last_grant_q <= sel_p1;
            we_q         <= sel_p1 ? p1_we    : buf_we_q;
            bus_addr     <= sel_p1 ? p1_addr  : buf_addr_q;
            bus_wdata    <= sel_p1 ? p1_wdata : buf_wdata_q;
        end
    end

    assign bus_read  = (state_q == ISSUE) && !we_q;
    assign bus_write = (state_q == ISSUE) && we_q;
    assign p1_gnt    = (state_q == ISSUE) && owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else if (p0_accept) begin
            buf_valid_q <= 1'b1;
            buf_we_q    <= p0_write;
            buf_addr_q  <= p0_addr;
            buf_wdata_q <= p0_wdata;
        end else if (p0_consume) begin
            buf_valid_q <= 1'b0;
        end
    end

    // Set wins over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_overrun <= 1'b0;
        end else if (p0_drop) begin
            p0_overrun <= 1'b1;
        end else if (p0_ovr_clr) begin
            p0_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= (state_q == RDWAIT) && !owner_q;
            p1_rvalid <= (state_q == RDWAIT) && owner_q;
            if (state_q == RDWAIT) begin
                if (owner_q) p1_rdata <= bus_rdata;
                else         p0_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: expected bus accesses and read results are queued as
// stimulus is driven and popped by a negedge monitor when the DUT produces them.
module tb_reg_arbiter;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_read, p0_write, p0_ovr_clr;
    logic [5:0] p0_addr;
    logic [7:0] p0_wdata, p0_rdata;
    logic       p0_rvalid, p0_overrun;
    logic       p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [5:0] p1_addr;
    logic [7:0] p1_wdata, p1_rdata;
    logic       bus_read, bus_write;
    logic [5:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;

    reg_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_overrun(p0_overrun),
        .p0_ovr_clr(p0_ovr_clr),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int bus_cnt = 0, p0rv_cnt = 0, p1rv_cnt = 0;
    int last_bus_cyc = 0, last_p0rv_cyc = 0;

    bus_t       bus_q[$];
    logic [7:0] p0_q[$];
    logic [7:0] p1_q[$];
    bus_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: read data is a fixed function of address, valid the cycle after bus_read.
    function automatic logic [7:0] bank(input logic [5:0] a);
        return {a, 2'b00} ^ 8'h34;
    endfunction

    logic       rd_pend = 1'b0;
    logic [5:0] rd_addr = '0;
    always @(posedge clk) begin
        rd_pend <= bus_read;
        rd_addr <= bus_addr;
    end
    assign bus_rdata = rd_pend ? bank(rd_addr) : 8'hEE;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_read || bus_write) begin
            bus_cnt++;
            last_bus_cyc = cyc;
            check("bus_access_expected", 64'(bus_q.size() != 0), 64'd1);
            if (bus_q.size() != 0) begin
                mon_e = bus_q.pop_front();
                check("bus_we", 64'({bus_write, bus_read}), 64'(mon_e.we ? 2'b10 : 2'b01));
                check("bus_addr", 64'(bus_addr), 64'(mon_e.addr));
                if (mon_e.we) check("bus_wdata", 64'(bus_wdata), 64'(mon_e.wdata));
            end
        end
        if (p0_rvalid) begin
            p0rv_cnt++;
            last_p0rv_cyc = cyc;
            check("p0_rvalid_expected", 64'(p0_q.size() != 0), 64'd1);
            if (p0_q.size() != 0) check("p0_rdata", 64'(p0_rdata), 64'(p0_q.pop_front()));
        end
        if (p1_rvalid) begin
            p1rv_cnt++;
            check("p1_rvalid_expected", 64'(p1_q.size() != 0), 64'd1);
            if (p1_q.size() != 0) check("p1_rdata", 64'(p1_rdata), 64'(p1_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input logic we, input logic [5:0] a, input logic [7:0] d);
        bus_t e;
        e.we = we; e.addr = a; e.wdata = d;
        bus_q.push_back(e);
    endtask

    task automatic p0_strobe(input logic rd, input logic wr, input logic [5:0] a,
                             input logic [7:0] d, input logic clr);
        p0_read = rd; p0_write = wr; p0_addr = a; p0_wdata = d; p0_ovr_clr = clr;
        tick();
        p0_read = 1'b0; p0_write = 1'b0; p0_ovr_clr = 1'b0;
    endtask

    // Hold a port 1 request until granted, bounded so a missing grant cannot hang the run.
    task automatic p1_go(input logic we, input logic [5:0] a, input logic [7:0] d);
        logic seen;
        seen = 1'b0;
        p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (p1_gnt) seen = 1'b1;
        end
        check("p1_gnt_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1 p1_req = 1'b0;
    endtask

    int t0, b0, r0;

    initial begin
        rst_n = 1'b0;
        p0_read = 0; p0_write = 0; p0_addr = '0; p0_wdata = '0; p0_ovr_clr = 0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (3) tick();
        check("reset_outputs", 64'({bus_read, bus_write, bus_addr, bus_wdata, p0_rdata, p0_rvalid,
              p0_overrun, p1_gnt, p1_rdata, p1_rvalid}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Tie right after reset: port 0 first, then port 1.
        exp_bus(0, 6'h03, 8'h00); p0_q.push_back(bank(6'h03));
        exp_bus(0, 6'h10, 8'h00); p1_q.push_back(bank(6'h10));
        p0_strobe(1, 0, 6'h03, 8'h00, 0);
        fork p1_go(0, 6'h10, 8'h00); join_none
        repeat (10) tick();
        check("p1_rdata_after_read", 64'(p1_rdata), 64'h74);
        // Second tie after port 1 was served: port 0 wins again.
        exp_bus(1, 6'h21, 8'h5A);
        exp_bus(1, 6'h11, 8'h99);
        p0_strobe(0, 1, 6'h21, 8'h5A, 0);
        fork p1_go(1, 6'h11, 8'h99); join_none
        repeat (8) tick();

        // Port 0 write latency: bus strobe exactly at N+2.
        exp_bus(1, 6'h05, 8'hA5);
        t0 = cyc; b0 = bus_cnt;
        p0_strobe(0, 1, 6'h05, 8'hA5, 0);
        repeat (4) tick();
        check("p0_wr_bus_count", 64'(bus_cnt - b0), 64'd1);
        check("p0_wr_latency", 64'(last_bus_cyc - t0), 64'd2);

        // Port 0 read latency: bus strobe N+2, single p0_rvalid at N+4.
        exp_bus(0, 6'h02, 8'h00); p0_q.push_back(8'h3C);
        t0 = cyc; r0 = p0rv_cnt;
        p0_strobe(1, 0, 6'h02, 8'h00, 0);
        repeat (6) tick();
        check("p0_rd_bus_latency", 64'(last_bus_cyc - t0), 64'd2);
        check("p0_rvalid_latency", 64'(last_p0rv_cyc - t0), 64'd4);
        check("p0_rvalid_count", 64'(p0rv_cnt - r0), 64'd1);
        check("p0_rdata_hold", 64'(p0_rdata), 64'h3C);

        // Read and write together: treated as write, overrun flagged.
        exp_bus(1, 6'h07, 8'h77);
        p0_strobe(1, 1, 6'h07, 8'h77, 0);
        check("overrun_rw_collision", 64'(p0_overrun), 64'd1);
        repeat (3) tick();

        // Three writes two cycles apart with a port 1 write winning the middle slot:
        // third is dropped; clear in the drop cycle must not win.
        exp_bus(1, 6'h30, 8'hD1);
        exp_bus(1, 6'h31, 8'hE1);
        exp_bus(1, 6'h32, 8'hD2);
        p0_strobe(0, 1, 6'h30, 8'hD1, 0);
        tick();
        fork p1_go(1, 6'h31, 8'hE1); join_none
        p0_strobe(0, 1, 6'h32, 8'hD2, 0);
        tick();
        p0_strobe(0, 1, 6'h33, 8'hD3, 1);
        check("overrun_after_drop_with_clr", 64'(p0_overrun), 64'd1);
        repeat (8) tick();
        check("dropped_write_never_issued", 64'(bus_q.size()), 64'd0);
        check("overrun_sticky", 64'(p0_overrun), 64'd1);
        p0_strobe(0, 0, 6'h00, 8'h00, 1);
        check("overrun_cleared", 64'(p0_overrun), 64'd0);
        check("p0_rdata_held_over_writes", 64'(p0_rdata), 64'h3C);

        // Reset during RDWAIT of a port 1 read: no rvalid afterwards, outputs zeroed.
        exp_bus(0, 6'h15, 8'h00);
        r0 = p1rv_cnt;
        fork p1_go(0, 6'h15, 8'h00); join_none
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1 check("reset_mid_access_outputs", 64'({bus_read, bus_write, bus_addr, bus_wdata, p0_rdata,
              p0_rvalid, p0_overrun, p1_gnt, p1_rdata, p1_rvalid}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_p1_rvalid_after_abort", 64'(p1rv_cnt - r0), 64'd0);

        // First requests after reset are served normally.
        exp_bus(1, 6'h08, 8'h42);
        t0 = cyc;
        p0_strobe(0, 1, 6'h08, 8'h42, 0);
        repeat (4) tick();
        check("post_reset_wr_latency", 64'(last_bus_cyc - t0), 64'd2);
        exp_bus(0, 6'h09, 8'h00); p1_q.push_back(bank(6'h09));
        fork p1_go(0, 6'h09, 8'h00); join_none
        repeat (8) tick();
        check("post_reset_p1_rdata", 64'(p1_rdata), 64'h10);

        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        check("p0_queue_drained", 64'(p0_q.size()), 64'd0);
        check("p1_queue_drained", 64'(p1_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
